// File: rtl/result_monitor_pkg.sv
// Shared types and default sizes for the result-bus monitor.
// The entry timestamp field exists only when RESULT_MONITOR_TS_EN is defined.
package result_monitor_pkg;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_TS_W   = 16;
   localparam int DEF_DEPTH  = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRIME = 2'd1,
      TRACK = 2'd2
   } mon_state_t;

   // Layout of one FIFO entry at the default widths; the top packs the same
   // {ts, data} order at its parameterized widths.
   typedef struct packed {
`ifdef RESULT_MONITOR_TS_EN
      logic [DEF_TS_W-1:0]   ts;
`endif
      logic [DEF_DATA_W-1:0] data;
   } mon_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO with occupancy count; a push into a full FIFO
// is accepted when a pop happens on the same edge.
module sync_fifo
   import result_monitor_pkg::*;
#(
   parameter int W     = DEF_DATA_W,
   parameter int DEPTH = DEF_DEPTH,
   parameter int CW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic [W-1:0]  wdata,
   input  logic          pop,
   output logic [W-1:0]  rdata,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   localparam int AW = $clog2(DEPTH);

   logic [DEPTH-1:0][W-1:0] mem_q;
   logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    do_push, do_pop;

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q + CW'(do_push) - CW'(do_pop);
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) mem_q[wr_ptr_q] <= wdata;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = cnt_q;

endmodule

// File: rtl/result_monitor.sv
// Result-bus change monitor: queues {timestamp, value} on every change of
// proc_data while armed. RESULT_MONITOR_TS_EN adds the timestamp counter.
module result_monitor
   import result_monitor_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int TS_W   = DEF_TS_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [DATA_W-1:0]        proc_data,
   input  logic                     arm,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [DATA_W-1:0]        rd_data,
   output logic [TS_W-1:0]          rd_time,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   input  logic                     clr_ovf
);

   localparam int CW = $clog2(DEPTH) + 1;
`ifdef RESULT_MONITOR_TS_EN
   localparam int ENTRY_W = TS_W + DATA_W;
`else
   localparam int ENTRY_W = DATA_W;
`endif

   mon_state_t          state_q, state_d;
   logic [DATA_W-1:0]   prev_q, prev_d;
   logic                ovf_q, ovf_d;
   logic                ev, pop, drop, full, empty;
   logic [ENTRY_W-1:0]  wdata, rdata;

   // IDLE primes on the very edge arm is first seen, so the first armed edge
   // is captured; PRIME shares that behaviour as a safe entry state.
   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      ev      = 1'b0;
      case (state_q)
         IDLE, PRIME: begin
            if (arm) begin
               ev      = 1'b1;
               prev_d  = proc_data;
               state_d = TRACK;
            end else begin
               state_d = IDLE;
            end
         end
         TRACK: begin
            if (!arm) begin
               state_d = IDLE;
            end else if (proc_data != prev_q) begin
               ev     = 1'b1;
               prev_d = proc_data;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign pop  = rd_valid && rd_ready;
   assign drop = ev && full && !pop;

   // A drop in the same cycle as clr_ovf keeps the flag set.
   always_comb begin
      ovf_d = ovf_q;
      if (clr_ovf) ovf_d = 1'b0;
      if (drop)    ovf_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         prev_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         ovf_q   <= ovf_d;
      end
   end

`ifdef RESULT_MONITOR_TS_EN
   logic [TS_W-1:0] ts_q, ts_d;

   assign ts_d = ts_q + TS_W'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) ts_q <= '0;
      else      ts_q <= ts_d;
   end

   assign wdata   = {ts_q, proc_data};
   assign rd_time = rdata[ENTRY_W-1 -: TS_W];
   assign rd_data = rdata[DATA_W-1:0];
`else
   assign wdata   = proc_data;
   assign rd_time = '0;
   assign rd_data = rdata;
`endif

   sync_fifo #(
      .W     (ENTRY_W),
      .DEPTH (DEPTH),
      .CW    (CW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (ev),
      .wdata (wdata),
      .pop   (pop),
      .rdata (rdata),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign rd_valid = !empty;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_result_monitor.sv
// Randomized plus scenario-driven bench for result_monitor against a
// queue-based reference model.
module tb_result_monitor;

   localparam int DW  = 16;
   localparam int TW  = 4;
   localparam int DEP = 8;
   localparam int CW  = $clog2(DEP) + 1;
`ifdef RESULT_MONITOR_TS_EN
   localparam bit TS_ON = 1'b1;
`else
   localparam bit TS_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [DW-1:0] proc_data = '0;
   logic          arm = 1'b0;
   logic          rd_ready = 1'b0;
   logic          clr_ovf = 1'b0;
   logic          rd_valid;
   logic [DW-1:0] rd_data;
   logic [TW-1:0] rd_time;
   logic [CW-1:0] count;
   logic          overflow;

   result_monitor #(.DATA_W(DW), .TS_W(TW), .DEPTH(DEP)) dut (
      .clk       (clk),
      .rst       (rst),
      .proc_data (proc_data),
      .arm       (arm),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .rd_time   (rd_time),
      .count     (count),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf)
   );

   always #5 clk = ~clk;

   // Reference model: list of captured {value, timestamp} plus flags.
   int q_data[$];
   int q_ts[$];
   int ts_m;
   int prev_m;
   bit have_prev;
   bit ovf_m;
   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_state();
      chk("valid", {31'd0, rd_valid}, (q_data.size() > 0) ? 1 : 0);
      chk("count", {{(32-CW){1'b0}}, count}, q_data.size());
      chk("ovf", {31'd0, overflow}, {31'd0, ovf_m});
      if (q_data.size() > 0) begin
         chk("data", {16'd0, rd_data}, q_data[0]);
         chk("time", {28'd0, rd_time}, TS_ON ? q_ts[0] : 0);
      end
   endtask

   // One clock: apply inputs, check pre-edge outputs, advance model, step.
   task automatic cyc(input int d, input bit a, input bit r, input bit c);
      bit ev, pop;
      proc_data = d[15:0];
      arm       = a;
      rd_ready  = r;
      clr_ovf   = c;
      #1;
      chk_state();
      pop = (q_data.size() > 0) && r;
      ev  = a && (!have_prev || (d[15:0] != prev_m[15:0]));
      if (a) begin
         prev_m    = d & 16'hFFFF;
         have_prev = 1'b1;
      end else begin
         have_prev = 1'b0;
      end
      if (pop) begin
         void'(q_data.pop_front());
         void'(q_ts.pop_front());
      end
      if (c) ovf_m = 1'b0;
      if (ev) begin
         if (q_data.size() < DEP) begin
            q_data.push_back(d & 16'hFFFF);
            q_ts.push_back(ts_m % (1 << TW));
         end else begin
            ovf_m = 1'b1;
         end
      end
      ts_m++;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Asynchronous reset between edges; outputs must clear before the next edge.
   task automatic do_reset();
      @(posedge clk);
      #2 rst = 1'b0;
      #1;
      chk("rst_valid", {31'd0, rd_valid}, 0);
      chk("rst_count", {{(32-CW){1'b0}}, count}, 0);
      chk("rst_ovf", {31'd0, overflow}, 0);
      chk("rst_time", {28'd0, rd_time}, 0);
      q_data.delete();
      q_ts.delete();
      ts_m      = 0;
      have_prev = 1'b0;
      ovf_m     = 1'b0;
      prev_m    = 0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   initial begin
      do_reset();

      // first capture at the first edge after release
      repeat (4) cyc(16'h1234, 1, 0, 0);
      chk("first_cnt", {{(32-CW){1'b0}}, count}, 1);
      chk("first_data", {16'd0, rd_data}, 32'h1234);
      chk("first_ts", {28'd0, rd_time}, 0);

      // change tracking after a fresh prime
      cyc(16'h1234, 0, 1, 0);
      cyc(16'h0001, 1, 0, 0);
      cyc(16'h0001, 1, 0, 0);
      cyc(16'h0002, 1, 0, 0);
      cyc(16'h0002, 1, 0, 0);
      cyc(16'h0003, 1, 0, 0);
      chk("trk_cnt", {{(32-CW){1'b0}}, count}, 3);

      // overflow: 10 changes into an 8-deep FIFO
      do_reset();
      for (int i = 0; i < 10; i++) cyc(16'h0100 + i, 1, 0, 0);
      chk("ovf_cnt", {{(32-CW){1'b0}}, count}, 8);
      chk("ovf_set", {31'd0, overflow}, 1);
      chk("ovf_head", {16'd0, rd_data}, 32'h0100);
      cyc(16'h0109, 1, 0, 1);
      chk("ovf_clr", {31'd0, overflow}, 0);
      chk("ovf_clr_cnt", {{(32-CW){1'b0}}, count}, 8);

      // full plus simultaneous pop
      cyc(16'h0200, 1, 1, 0);
      chk("fullpop_cnt", {{(32-CW){1'b0}}, count}, 8);
      chk("fullpop_ovf", {31'd0, overflow}, 0);

      // drain with arm low, then re-arm on an unchanged bus
      repeat (9) cyc(16'h0200, 0, 1, 0);
      cyc(16'h0200, 1, 0, 0);
      chk("rearm_cnt", {{(32-CW){1'b0}}, count}, 1);
      chk("rearm_data", {16'd0, rd_data}, 32'h0200);

      // random traffic, including clr_ovf collisions and timestamp wraps
      for (int i = 0; i < 300; i++)
         cyc(16'hA000 + $urandom_range(0, 3), $urandom_range(0, 9) != 0,
             $urandom_range(0, 1) != 0, $urandom_range(0, 15) == 0);

      // mid-operation reset (checks live inside do_reset)
      do_reset();

      // timestamp wrap: change at edge 17 with a 4-bit counter
      repeat (17) cyc(16'h0055, 1, 1, 0);
      cyc(16'h0066, 1, 1, 0);
      chk("wrap_data", {16'd0, rd_data}, 32'h0066);
      chk("wrap_ts", {28'd0, rd_time}, TS_ON ? 1 : 0);
      cyc(16'h0066, 1, 1, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
